phased_array_gen: RTL

PHASED_ARRAY_GEN -- requirements
Module: phased_array_gen

---
 rtl/phased_array_pkg.sv | 23 ++
 rtl/phased_array_gen_wav_chan.sv | 71 +++++++
 rtl/phased_array_gen.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/phased_array_pkg.sv
// ---------------------------------------------------------------------------
// phased_array_pkg
// Shared constants and types for the phased-array waveform generator.
//   DEF_NUM_CH  : default number of transducer channels
//   DEF_PHASE_W : default phase resolution in bits (STEPS = 2**PHASE_W)
//   DEF_CLK_DIV : default clocks per phase step
//   phase_t     : phase/step value at the default resolution
//   half_steps(): 50 % duty expressed in steps for a given phase width
// ---------------------------------------------------------------------------
package phased_array_pkg;

  localparam int DEF_NUM_CH  = 64;
  localparam int DEF_PHASE_W = 5;
  localparam int DEF_CLK_DIV = 39;
  localparam int DEF_STEPS   = 2 ** DEF_PHASE_W;

  typedef logic [DEF_PHASE_W-1:0] phase_t;

  function automatic int half_steps(input int phase_w);
    return (2 ** phase_w) / 2;
  endfunction

endpackage

// File: rtl/phased_array_gen_wav_chan.sv
// ---------------------------------------------------------------------------
// wav_chan
// One transducer channel: shadow and active phase/enable registers, the
// phase-window compare and the registered drive output.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_wr        : write strobe already decoded for this channel
//   i_wr_phase  : new shadow phase (steps)
//   i_wr_chen   : new shadow enable
//   i_xfer      : shadow-to-active transfer on this edge
//   i_step      : current step counter value
//   i_duty      : active high-time in steps
//   o_wav       : registered channel drive
// ---------------------------------------------------------------------------
module wav_chan
  import phased_array_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_wr,
  input  logic [PHASE_W-1:0] i_wr_phase,
  input  logic               i_wr_chen,
  input  logic               i_xfer,
  input  logic [PHASE_W-1:0] i_step,
  input  logic [PHASE_W-1:0] i_duty,
  output logic               o_wav
);

  logic [PHASE_W-1:0] r_ph_sh;
  logic               r_en_sh;
  logic [PHASE_W-1:0] r_ph_act;
  logic               r_en_act;
  logic [PHASE_W-1:0] w_rel;

  // Step relative to this channel's phase; PHASE_W-bit subtraction gives the
  // modulo-STEPS wrap for free.
  assign w_rel = i_step - r_ph_act;

  // A write landing on the transfer edge must reach the active copy too, so
  // the active register takes the incoming data rather than the old shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ph_sh  <= '0;
      r_en_sh  <= 1'b0;
      r_ph_act <= '0;
      r_en_act <= 1'b0;
    end else begin
      if (i_wr) begin
        r_ph_sh <= i_wr_phase;
        r_en_sh <= i_wr_chen;
      end
      if (i_xfer) begin
        r_ph_act <= i_wr ? i_wr_phase : r_ph_sh;
        r_en_act <= i_wr ? i_wr_chen  : r_en_sh;
      end
    end
  end

  // Registered output: duty of zero can never satisfy the compare, so the
  // line stays low without glitching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_wav <= 1'b0;
    end else begin
      o_wav <= r_en_act && (w_rel < i_duty);
    end
  end

endmodule

// File: rtl/phased_array_gen.sv
// ---------------------------------------------------------------------------
// phased_array_gen
// Multi-channel phase-shifted square-wave generator for ultrasonic arrays.
// Channel settings are written to shadow registers and copied to the active
// set at the next carrier-period boundary after a commit request.
// Optional feature macro: DUTY_CTRL_EN (runtime duty control via 'duty').
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   wr_en     : shadow write strobe
//   wr_addr   : channel index for the write
//   wr_phase  : channel phase offset in steps
//   wr_chen   : channel enable
//   duty      : high-time in steps (used only with DUTY_CTRL_EN)
//   commit    : request shadow-to-active transfer at next boundary
//   wav       : per-channel drive waveforms
//   sync_out  : one-clock pulse aligned with the step-0 output update
//   busy      : commit pending
// ---------------------------------------------------------------------------
module phased_array_gen
  import phased_array_pkg::*;
#(
  parameter  int NUM_CH  = DEF_NUM_CH,
  parameter  int PHASE_W = DEF_PHASE_W,
  parameter  int CLK_DIV = DEF_CLK_DIV,
  localparam int AW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [PHASE_W-1:0] wr_phase,
  input  logic               wr_chen,
  input  logic [PHASE_W-1:0] duty,
  input  logic               commit,
  output logic [NUM_CH-1:0]  wav,
  output logic               sync_out,
  output logic               busy
);

  localparam int PRW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PHASE_W-1:0] HALF_DUTY = PHASE_W'(half_steps(PHASE_W));

  logic [PRW-1:0]     r_presc;
  logic [PHASE_W-1:0] r_step;
  logic               r_pending;
  logic               r_sync;
  logic               w_presc_tc;
  logic               w_bound;
  logic               w_xfer;
  logic               w_addr_ok;
  logic [PHASE_W-1:0] w_duty_act;

  assign w_presc_tc = (r_presc == PRW'(CLK_DIV - 1));
  assign w_bound    = w_presc_tc && (r_step == {PHASE_W{1'b1}});
  // A commit arriving on the boundary itself transfers immediately.
  assign w_xfer     = w_bound && (r_pending || commit);
  assign busy       = r_pending;
  assign sync_out   = r_sync;

  // Out-of-range addresses only exist when NUM_CH is not a power of two.
  if ((1 << AW) == NUM_CH) begin : g_addr_full
    assign w_addr_ok = 1'b1;
  end else begin : g_addr_chk
    assign w_addr_ok = (32'(wr_addr) < 32'(NUM_CH));
  end

  // Prescaler and step counter; the step wraps naturally at PHASE_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_step  <= '0;
    end else if (w_presc_tc) begin
      r_presc <= '0;
      r_step  <= r_step + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Sync is registered from the counter state so it lines up with the
  // registered wav update for step 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 1'b0;
    end else begin
      r_sync <= (r_presc == '0) && (r_step == '0);
    end
  end

  // Pending flag: set by commit, cleared by the transfer on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else if (w_xfer) begin
      r_pending <= 1'b0;
    end else if (commit) begin
      r_pending <= 1'b1;
    end
  end

`ifdef DUTY_CTRL_EN
  logic [PHASE_W-1:0] r_duty_sh;
  logic [PHASE_W-1:0] r_duty_act;
  logic               w_commit_new;

  // Only a commit that opens a new pending window samples duty.
  assign w_commit_new = commit && !r_pending;
  assign w_duty_act   = r_duty_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty_sh  <= HALF_DUTY;
      r_duty_act <= HALF_DUTY;
    end else begin
      if (w_commit_new) begin
        r_duty_sh <= duty;
      end
      if (w_xfer) begin
        r_duty_act <= w_commit_new ? duty : r_duty_sh;
      end
    end
  end
`else
  logic w_duty_unused;

  assign w_duty_unused = ^duty;
  assign w_duty_act    = HALF_DUTY;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    logic w_hit;

    assign w_hit = wr_en && w_addr_ok && (wr_addr == AW'(gi));

    wav_chan #(
      .PHASE_W (PHASE_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .i_wr       (w_hit),
      .i_wr_phase (wr_phase),
      .i_wr_chen  (wr_chen),
      .i_xfer     (w_xfer),
      .i_step     (r_step),
      .i_duty     (w_duty_act),
      .o_wav      (wav[gi])
    );
  end

endmodule
